// File: rtl/control_unit_if.sv
// Control bundle between the control unit and the CPU datapath: IR/flag/halt-request
// inputs to the controller, run status and every datapath strobe back out.
interface control_unit_if;
    logic [31:0] ir;
    logic        con_ff;
    logic        stop;
    logic        run;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        R15in;
    logic        PCout, PCin, IncPC;
    logic        MARin, MDRin, MDRout, Read, Write;
    logic        IRin, Yin, Zin, Zhighout, Zlowout, Cout, CONin;
    logic        HIin, HIout, LOin, LOout, InPortout, OutPortin;
    logic [4:0]  alu_op;

    modport master (
        input  ir, con_ff, stop,
        output run, Gra, Grb, Grc, Rin, Rout, BAout, R15in,
               PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write,
               IRin, Yin, Zin, Zhighout, Zlowout, Cout, CONin,
               HIin, HIout, LOin, LOout, InPortout, OutPortin, alu_op
    );

    modport slave (
        output ir, con_ff, stop,
        input  run, Gra, Grb, Grc, Rin, Rout, BAout, R15in,
               PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write,
               IRin, Yin, Zin, Zhighout, Zlowout, Cout, CONin,
               HIin, HIout, LOin, LOout, InPortout, OutPortin, alu_op
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired multi-cycle control FSM: 3-cycle fetch then per-class execute steps T3..T7.
// Latency: 4..8 cycles per instruction; strobes are a combinational decode of state/opcode.
// No backpressure: stop is honoured only at an instruction's final edge; clear aborts at once.
module control_unit #(
    parameter bit HALT_ON_UNDEF = 1'b0
) (
    input  logic           clock,
    input  logic           clear,
    control_unit_if.master cu
);

    localparam logic [3:0] T0   = 4'd0;
    localparam logic [3:0] T1   = 4'd1;
    localparam logic [3:0] T2   = 4'd2;
    localparam logic [3:0] T3   = 4'd3;
    localparam logic [3:0] T4   = 4'd4;
    localparam logic [3:0] T5   = 4'd5;
    localparam logic [3:0] T6   = 4'd6;
    localparam logic [3:0] T7   = 4'd7;
    localparam logic [3:0] HALT = 4'd8;

    localparam logic [4:0] ALU_ADD = 5'b00011;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       done;
    logic [4:0] op;

    logic is_alu3, is_imm, is_unary, is_muldiv;
    logic is_ld, is_ldi, is_st, is_brx, is_jr, is_jal;
    logic is_in, is_out, is_mfhi, is_mflo, is_halt;
    logic unused_ir_bits;

    assign op             = cu.ir[31:27];
    assign unused_ir_bits = ^cu.ir[26:0];

    assign is_alu3   = (op >= 5'd3)  && (op <= 5'd11);
    assign is_imm    = (op >= 5'd12) && (op <= 5'd14);
    assign is_muldiv = (op == 5'd15) || (op == 5'd16);
    assign is_unary  = (op == 5'd17) || (op == 5'd18);
    assign is_ld     = (op == 5'd0);
    assign is_ldi    = (op == 5'd1);
    assign is_st     = (op == 5'd2);
    assign is_brx    = (op == 5'd19);
    assign is_jr     = (op == 5'd20);
    assign is_jal    = (op == 5'd21);
    assign is_in     = (op == 5'd22);
    assign is_out    = (op == 5'd23);
    assign is_mfhi   = (op == 5'd24);
    assign is_mflo   = (op == 5'd25);
    assign is_halt   = (op == 5'd27) || (HALT_ON_UNDEF && (op >= 5'd28));

    // Sequencing: each class leaves at its own last step; the branch skips T6 when not taken.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            T0: state_nxt = T1;
            T1: state_nxt = T2;
            T2: state_nxt = T3;
            T3: begin
                if (is_halt)
                    state_nxt = HALT;
                else if (is_alu3 | is_imm | is_unary | is_muldiv | is_ld | is_ldi |
                         is_st | is_brx | is_jal)
                    state_nxt = T4;
                else
                    done = 1'b1;
            end
            T4: begin
                if (is_unary | is_jal) done = 1'b1;
                else                   state_nxt = T5;
            end
            T5: begin
                if (is_alu3 | is_imm | is_ldi | (is_brx & ~cu.con_ff)) done = 1'b1;
                else                                                   state_nxt = T6;
            end
            T6: begin
                if (is_muldiv | is_brx) done = 1'b1;
                else                    state_nxt = T7;
            end
            T7:      done      = 1'b1;
            HALT:    state_nxt = HALT;
            default: state_nxt = T0;
        endcase
        if (done)
            state_nxt = cu.stop ? HALT : T0;
    end

    always_ff @(posedge clock) begin
        if (clear) state <= T0;
        else       state <= state_nxt;
    end

    always_comb begin
        cu.run       = ~clear && (state != HALT);
        cu.alu_op    = ALU_ADD;
        cu.Gra       = 1'b0; cu.Grb      = 1'b0; cu.Grc     = 1'b0;
        cu.Rin       = 1'b0; cu.Rout     = 1'b0; cu.BAout   = 1'b0;
        cu.R15in     = 1'b0; cu.PCout    = 1'b0; cu.PCin    = 1'b0;
        cu.IncPC     = 1'b0; cu.MARin    = 1'b0; cu.MDRin   = 1'b0;
        cu.MDRout    = 1'b0; cu.Read     = 1'b0; cu.Write   = 1'b0;
        cu.IRin      = 1'b0; cu.Yin      = 1'b0; cu.Zin     = 1'b0;
        cu.Zhighout  = 1'b0; cu.Zlowout  = 1'b0; cu.Cout    = 1'b0;
        cu.CONin     = 1'b0; cu.HIin     = 1'b0; cu.HIout   = 1'b0;
        cu.LOin      = 1'b0; cu.LOout    = 1'b0; cu.InPortout = 1'b0;
        cu.OutPortin = 1'b0;
        if (!clear) begin
            case (state)
                T0: begin cu.PCout = 1'b1; cu.MARin = 1'b1; cu.IncPC = 1'b1; end
                T1: begin cu.Read = 1'b1; cu.MDRin = 1'b1; end
                T2: begin cu.MDRout = 1'b1; cu.IRin = 1'b1; end
                T3: begin
                    if (is_alu3 | is_imm) begin cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
                    if (is_unary) begin
                        cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1; cu.alu_op = op;
                    end
                    if (is_muldiv) begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.Yin = 1'b1; end
                    if (is_ld | is_ldi | is_st) begin cu.Grb = 1'b1; cu.BAout = 1'b1; cu.Yin = 1'b1; end
                    if (is_brx) begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.CONin = 1'b1; end
                    if (is_jr)  begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1; end
                    if (is_jal) begin cu.PCout = 1'b1; cu.R15in = 1'b1; end
                    if (is_in)  begin cu.InPortout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
                    if (is_out) begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.OutPortin = 1'b1; end
                    if (is_mfhi) begin cu.HIout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
                    if (is_mflo) begin cu.LOout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
                end
                T4: begin
                    if (is_alu3) begin
                        cu.Grc = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1; cu.alu_op = op;
                    end
                    if (is_imm) begin cu.Cout = 1'b1; cu.Zin = 1'b1; cu.alu_op = op; end
                    if (is_unary) begin cu.Zlowout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
                    if (is_muldiv) begin
                        cu.Grb = 1'b1; cu.Rout = 1'b1; cu.Zin = 1'b1; cu.alu_op = op;
                    end
                    if (is_ld | is_ldi | is_st) begin cu.Cout = 1'b1; cu.Zin = 1'b1; end
                    if (is_brx) begin cu.PCout = 1'b1; cu.Yin = 1'b1; end
                    if (is_jal) begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.PCin = 1'b1; end
                end
                T5: begin
                    if (is_alu3 | is_imm | is_ldi) begin
                        cu.Zlowout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1;
                    end
                    if (is_muldiv) begin cu.Zlowout = 1'b1; cu.LOin = 1'b1; end
                    if (is_ld | is_st) begin cu.Zlowout = 1'b1; cu.MARin = 1'b1; end
                    if (is_brx) begin cu.Cout = 1'b1; cu.Zin = 1'b1; end
                end
                T6: begin
                    if (is_muldiv) begin cu.Zhighout = 1'b1; cu.HIin = 1'b1; end
                    if (is_ld) begin cu.Read = 1'b1; cu.MDRin = 1'b1; end
                    // Store data comes from the register file, so Read stays low here.
                    if (is_st) begin cu.Gra = 1'b1; cu.Rout = 1'b1; cu.MDRin = 1'b1; end
                    if (is_brx) begin cu.Zlowout = 1'b1; cu.PCin = 1'b1; end
                end
                T7: begin
                    if (is_ld) begin cu.MDRout = 1'b1; cu.Gra = 1'b1; cu.Rin = 1'b1; end
                    if (is_st) cu.Write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: each instruction is expanded into its expected per-cycle
// strobe list and compared cycle by cycle, including halt, stop and clear paths.
module tb_control_unit;

    logic clock = 1'b0;
    logic clear;
    always #5 clock = ~clock;

    control_unit_if cu();

    control_unit #(.HALT_ON_UNDEF(1'b0)) dut (
        .clock (clock),
        .clear (clear),
        .cu    (cu.master)
    );

    localparam logic [27:0] GRA = 28'd1 << 27, GRB = 28'd1 << 26, GRC = 28'd1 << 25;
    localparam logic [27:0] RIN = 28'd1 << 24, ROUT = 28'd1 << 23, BAOUT = 28'd1 << 22;
    localparam logic [27:0] R15IN = 28'd1 << 21, PCOUT = 28'd1 << 20, PCIN = 28'd1 << 19;
    localparam logic [27:0] INCPC = 28'd1 << 18, MARIN = 28'd1 << 17, MDRIN = 28'd1 << 16;
    localparam logic [27:0] MDROUT = 28'd1 << 15, READ = 28'd1 << 14, WRITE = 28'd1 << 13;
    localparam logic [27:0] IRIN = 28'd1 << 12, YIN = 28'd1 << 11, ZIN = 28'd1 << 10;
    localparam logic [27:0] ZHIGHOUT = 28'd1 << 9, ZLOWOUT = 28'd1 << 8, COUT = 28'd1 << 7;
    localparam logic [27:0] CONIN = 28'd1 << 6, HIIN = 28'd1 << 5, HIOUT = 28'd1 << 4;
    localparam logic [27:0] LOIN = 28'd1 << 3, LOOUT = 28'd1 << 2, INPORTOUT = 28'd1 << 1;
    localparam logic [27:0] OUTPORTIN = 28'd1 << 0;
    localparam logic [4:0]  ADD = 5'b00011;
    localparam logic [33:0] IDLE_WORD = {28'd0, ADD, 1'b0};

    logic [33:0] obs;
    assign obs = {cu.Gra, cu.Grb, cu.Grc, cu.Rin, cu.Rout, cu.BAout, cu.R15in, cu.PCout,
                  cu.PCin, cu.IncPC, cu.MARin, cu.MDRin, cu.MDRout, cu.Read, cu.Write,
                  cu.IRin, cu.Yin, cu.Zin, cu.Zhighout, cu.Zlowout, cu.Cout, cu.CONin,
                  cu.HIin, cu.HIout, cu.LOin, cu.LOout, cu.InPortout, cu.OutPortin,
                  cu.alu_op, cu.run};

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];

    function automatic logic [33:0] w(input logic [27:0] s, input logic [4:0] a);
        return {s, a, 1'b1};
    endfunction

    task automatic chk(input logic [33:0] e, input string tag);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    // Reference: the full per-cycle strobe list of one instruction, fetch included.
    task automatic build(input logic [4:0] op, input logic c);
        exp_q.delete();
        exp_q.push_back(w(PCOUT | MARIN | INCPC, ADD));
        exp_q.push_back(w(READ | MDRIN, ADD));
        exp_q.push_back(w(MDROUT | IRIN, ADD));
        if (op >= 5'd3 && op <= 5'd11) begin
            exp_q.push_back(w(GRB | ROUT | YIN, ADD));
            exp_q.push_back(w(GRC | ROUT | ZIN, op));
            exp_q.push_back(w(ZLOWOUT | GRA | RIN, ADD));
        end else if (op >= 5'd12 && op <= 5'd14) begin
            exp_q.push_back(w(GRB | ROUT | YIN, ADD));
            exp_q.push_back(w(COUT | ZIN, op));
            exp_q.push_back(w(ZLOWOUT | GRA | RIN, ADD));
        end else if (op == 5'd17 || op == 5'd18) begin
            exp_q.push_back(w(GRB | ROUT | ZIN, op));
            exp_q.push_back(w(ZLOWOUT | GRA | RIN, ADD));
        end else if (op == 5'd15 || op == 5'd16) begin
            exp_q.push_back(w(GRA | ROUT | YIN, ADD));
            exp_q.push_back(w(GRB | ROUT | ZIN, op));
            exp_q.push_back(w(ZLOWOUT | LOIN, ADD));
            exp_q.push_back(w(ZHIGHOUT | HIIN, ADD));
        end else if (op <= 5'd2) begin
            exp_q.push_back(w(GRB | BAOUT | YIN, ADD));
            exp_q.push_back(w(COUT | ZIN, ADD));
            if (op == 5'd1) exp_q.push_back(w(ZLOWOUT | GRA | RIN, ADD));
            else            exp_q.push_back(w(ZLOWOUT | MARIN, ADD));
            if (op == 5'd0) begin
                exp_q.push_back(w(READ | MDRIN, ADD));
                exp_q.push_back(w(MDROUT | GRA | RIN, ADD));
            end else if (op == 5'd2) begin
                exp_q.push_back(w(GRA | ROUT | MDRIN, ADD));
                exp_q.push_back(w(WRITE, ADD));
            end
        end else if (op == 5'd19) begin
            exp_q.push_back(w(GRA | ROUT | CONIN, ADD));
            exp_q.push_back(w(PCOUT | YIN, ADD));
            exp_q.push_back(w(COUT | ZIN, ADD));
            if (c) exp_q.push_back(w(ZLOWOUT | PCIN, ADD));
        end else if (op == 5'd20) exp_q.push_back(w(GRA | ROUT | PCIN, ADD));
        else if (op == 5'd21) begin
            exp_q.push_back(w(PCOUT | R15IN, ADD));
            exp_q.push_back(w(GRA | ROUT | PCIN, ADD));
        end
        else if (op == 5'd22) exp_q.push_back(w(INPORTOUT | GRA | RIN, ADD));
        else if (op == 5'd23) exp_q.push_back(w(GRA | ROUT | OUTPORTIN, ADD));
        else if (op == 5'd24) exp_q.push_back(w(HIOUT | GRA | RIN, ADD));
        else if (op == 5'd25) exp_q.push_back(w(LOOUT | GRA | RIN, ADD));
        else exp_q.push_back(w(28'd0, ADD));
    endtask

    // stop is driven for the edge ending step k: a single pulse, or held from stop_step on.
    task automatic run_instr(input logic [31:0] word, input logic c, input int stop_step,
                             input bit stop_hold, input string tag);
        build(word[31:27], c);
        cu.ir     = word;
        cu.con_ff = c;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clock);
            chk(exp_q[k], $sformatf("%s_t%0d", tag, k));
            cu.stop = (stop_step >= 0) && ((k == stop_step) || (stop_hold && k >= stop_step));
        end
        @(posedge clock);
        #1 cu.stop = 1'b0;
    endtask

    task automatic expect_halt(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk(IDLE_WORD, $sformatf("%s_%0d", tag, i));
        end
    endtask

    task automatic do_clear(input int n, input string tag);
        clear = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk(IDLE_WORD, $sformatf("%s_%0d", tag, i));
        end
        @(posedge clock);
        #1 clear = 1'b0;
    endtask

    logic [4:0]  rop;
    logic [31:0] rword;
    logic        rc;

    initial begin
        clear     = 1'b1;
        cu.ir     = 32'd0;
        cu.con_ff = 1'b0;
        cu.stop   = 1'b0;
        expect_halt(2, "reset");
        @(posedge clock);
        #1 clear = 1'b0;

        // Clear held in T4 of an add aborts it and restarts at fetch.
        build(5'd3, 1'b0);
        cu.ir = 32'h18918000;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clock);
            chk(exp_q[k], $sformatf("pre_clear_t%0d", k));
        end
        do_clear(3, "mid_clear");

        run_instr(32'h18918000, 1'b0, -1, 1'b0, "add");
        run_instr({5'd0, 4'd2, 4'd1, 19'h95}, 1'b0, -1, 1'b0, "ld");
        run_instr({5'd19, 4'd3, 23'h1234}, 1'b0, -1, 1'b0, "brx_nt");
        run_instr({5'd19, 4'd3, 23'h1234}, 1'b1, -1, 1'b0, "brx_t");
        run_instr({5'd15, 4'd4, 4'd5, 19'd0}, 1'b0, -1, 1'b0, "mul");
        run_instr({5'd21, 27'd0}, 1'b0, -1, 1'b0, "jal");
        run_instr({5'd13, 27'h55}, 1'b0, -1, 1'b0, "andi");
        run_instr({5'd30, 27'd0}, 1'b0, -1, 1'b0, "undef_nop");

        run_instr({5'd27, 27'd0}, 1'b0, -1, 1'b0, "halt");
        expect_halt(20, "halted");
        do_clear(2, "halt_clear");

        run_instr({5'd2, 4'd6, 4'd7, 19'h10}, 1'b0, 4, 1'b0, "st_pulse");
        run_instr({5'd26, 27'd0}, 1'b0, -1, 1'b0, "nop_after_pulse");
        run_instr({5'd2, 4'd6, 4'd7, 19'h10}, 1'b0, 4, 1'b1, "st_hold");
        expect_halt(3, "st_halted");
        do_clear(1, "st_clear");

        run_instr({5'd18, 27'd0}, 1'b0, 3, 1'b1, "not_stop");
        expect_halt(2, "not_halted");
        cu.stop = 1'b1;
        do_clear(1, "stop_and_clear");
        cu.stop = 1'b0;

        for (int n = 0; n < 80; n++) begin
            rop = 5'($urandom_range(0, 31));
            if (rop == 5'd27) rop = 5'd26;
            rword = {rop, 27'($urandom)};
            rc    = 1'($urandom_range(0, 1));
            run_instr(rword, rc, -1, 1'b0, $sformatf("rnd%0d_op%0d", n, rop));
        end
        run_instr({5'd22, 27'd0}, 1'b0, 3, 1'b0, "in_stop");
        expect_halt(2, "final_halt");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
